player_attack_combo: RTL and testbench

Next-generation player attack controller supporting three attack types (ATK1/ATK2/ATK3), each with its own parametrised frame timing. Adds buffered combo chaining up to a combo limit, a post-attack cooldown, and hit-stun interruption. Sits between the debounced button pulses and the sprite/hitbox logic. Advances only on the per-frame SCEN tick.

---
 rtl/player_attack_combo.sv | 223 ++++++++++++++++++++++
 tb/tb_player_attack_combo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/player_attack_combo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | player_attack_combo                                                      |
// | Three-type attack controller with buffered combo chaining, cooldown and  |
// | hit-stun abort; advances only on SCEN ticks.                             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module player_attack_combo #(
  parameter int FRAME_W    = 6,
  parameter int ATK1_TOTAL = 18,
  parameter int ATK1_START = 4,
  parameter int ATK1_END   = 10,
  parameter int ATK2_TOTAL = 24,
  parameter int ATK2_START = 6,
  parameter int ATK2_END   = 14,
  parameter int ATK3_TOTAL = 30,
  parameter int ATK3_START = 10,
  parameter int ATK3_END   = 20,
  parameter int BUFFER_WIN = 6,
  parameter int COOLDOWN   = 8,
  parameter int MAX_COMBO  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               SCEN,
  input  logic               attack_enable,
  input  logic               attack1,
  input  logic               attack2,
  input  logic               attack3,
  input  logic               hit_stun,
  output logic               attack_busy,
  output logic               attack_active,
  output logic [1:0]         attack_type,
  output logic [FRAME_W-1:0] attack_frame,
  output logic               attack_start,
  output logic               cooldown_active,
  output logic [1:0]         combo_count
);

  localparam int c_CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [c_CD_W-1:0] c_CD_LOAD = c_CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [FRAME_W:0]  c_BUF_WIN = (FRAME_W+1)'(BUFFER_WIN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ATTACK   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t              r_state, w_state;
  logic [1:0]          r_type, w_type;
  logic [FRAME_W-1:0]  r_frame, w_frame;
  logic [1:0]          r_combo, w_combo;
  logic                r_buf_valid, w_buf_valid;
  logic [1:0]          r_buf_type, w_buf_type;
  logic [c_CD_W-1:0]   r_cd_cnt, w_cd_cnt;
  logic                r_active, w_active;
  logic                r_start, w_start;
  logic                r_cd_active, w_cd_active;

  logic                w_req;
  logic [1:0]          w_req_type;
  logic [FRAME_W:0]    w_tot, w_win_start, w_win_end;
  logic                w_in_win, w_last;

  function automatic logic [FRAME_W:0] f_total(input logic [1:0] t);
    case (t)
      2'd1:    f_total = (FRAME_W+1)'(ATK1_TOTAL);
      2'd2:    f_total = (FRAME_W+1)'(ATK2_TOTAL);
      2'd3:    f_total = (FRAME_W+1)'(ATK3_TOTAL);
      default: f_total = '0;
    endcase
  endfunction

  function automatic logic [FRAME_W:0] f_start(input logic [1:0] t);
    case (t)
      2'd1:    f_start = (FRAME_W+1)'(ATK1_START);
      2'd2:    f_start = (FRAME_W+1)'(ATK2_START);
      2'd3:    f_start = (FRAME_W+1)'(ATK3_START);
      default: f_start = '0;
    endcase
  endfunction

  function automatic logic [FRAME_W:0] f_end(input logic [1:0] t);
    case (t)
      2'd1:    f_end = (FRAME_W+1)'(ATK1_END);
      2'd2:    f_end = (FRAME_W+1)'(ATK2_END);
      2'd3:    f_end = (FRAME_W+1)'(ATK3_END);
      default: f_end = '0;
    endcase
  endfunction

  always_comb begin
    w_req      = attack1 | attack2 | attack3;
    w_req_type = attack3 ? 2'd3 : (attack2 ? 2'd2 : (attack1 ? 2'd1 : 2'd0));
    w_tot      = f_total(r_type);
    w_in_win   = ({1'b0, r_frame} >= (w_tot - c_BUF_WIN));
    w_last     = ({1'b0, r_frame} == (w_tot - 1'b1));
  end

  always_comb begin
    w_state     = r_state;
    w_type      = r_type;
    w_frame     = r_frame;
    w_combo     = r_combo;
    w_buf_valid = r_buf_valid;
    w_buf_type  = r_buf_type;
    w_cd_cnt    = r_cd_cnt;
    w_cd_active = r_cd_active;
    w_start     = 1'b0;

    if (SCEN) begin
      if (hit_stun) begin
        w_state     = S_IDLE;
        w_type      = 2'd0;
        w_frame     = '0;
        w_combo     = 2'd0;
        w_buf_valid = 1'b0;
        w_buf_type  = 2'd0;
        w_cd_cnt    = '0;
        w_cd_active = 1'b0;
      end else if (attack_enable) begin
        case (r_state)
          S_IDLE: begin
            if (w_req) begin
              w_state = S_ATTACK;
              w_type  = w_req_type;
              w_frame = '0;
              w_combo = 2'd0;
              w_start = 1'b1;
            end
          end
          S_ATTACK: begin
            // A press on the final frame still counts toward the chain decision.
            if (w_req && w_in_win) begin
              w_buf_valid = 1'b1;
              w_buf_type  = w_req_type;
            end
            if (w_last) begin
              w_buf_valid = 1'b0;
              w_buf_type  = 2'd0;
              w_frame     = '0;
              if ((r_buf_valid || (w_req && w_in_win)) && (int'(r_combo) < MAX_COMBO - 1)) begin
                w_type  = (w_req && w_in_win) ? w_req_type : r_buf_type;
                w_combo = r_combo + 2'd1;
                w_start = 1'b1;
              end else begin
                w_type  = 2'd0;
                w_combo = 2'd0;
                if (COOLDOWN == 0) begin
                  w_state = S_IDLE;
                end else begin
                  w_state     = S_COOLDOWN;
                  w_cd_cnt    = c_CD_LOAD;
                  w_cd_active = 1'b1;
                end
              end
            end else begin
              w_frame = r_frame + FRAME_W'(1);
            end
          end
          S_COOLDOWN: begin
            if (r_cd_cnt == '0) begin
              w_cd_active = 1'b0;
              w_state     = S_IDLE;
              if (w_req) begin
                w_state = S_ATTACK;
                w_type  = w_req_type;
                w_frame = '0;
                w_combo = 2'd0;
                w_start = 1'b1;
              end
            end else begin
              w_cd_cnt = r_cd_cnt - c_CD_W'(1);
            end
          end
          default: w_state = S_IDLE;
        endcase
      end
    end

    w_win_start = f_start(w_type);
    w_win_end   = f_end(w_type);
    w_active    = (w_state == S_ATTACK) &&
                  ({1'b0, w_frame} >= w_win_start) && ({1'b0, w_frame} <= w_win_end);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_type      <= 2'd0;
      r_frame     <= '0;
      r_combo     <= 2'd0;
      r_buf_valid <= 1'b0;
      r_buf_type  <= 2'd0;
      r_cd_cnt    <= '0;
      r_active    <= 1'b0;
      r_start     <= 1'b0;
      r_cd_active <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_type      <= w_type;
      r_frame     <= w_frame;
      r_combo     <= w_combo;
      r_buf_valid <= w_buf_valid;
      r_buf_type  <= w_buf_type;
      r_cd_cnt    <= w_cd_cnt;
      r_active    <= w_active;
      r_start     <= w_start;
      r_cd_active <= w_cd_active;
    end
  end

  assign attack_busy     = (r_state == S_ATTACK);
  assign attack_active   = r_active;
  assign attack_type     = r_type;
  assign attack_frame    = r_frame;
  assign attack_start    = r_start;
  assign cooldown_active = r_cd_active;
  assign combo_count     = r_combo;

endmodule
`default_nettype wire

// File: tb/tb_player_attack_combo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_player_attack_combo                                                   |
// | Directed self-checking bench for player_attack_combo (default params).   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_player_attack_combo;

  logic       clk = 1'b0;
  logic       reset;
  logic       SCEN;
  logic       attack_enable;
  logic       attack1, attack2, attack3;
  logic       hit_stun;
  logic       attack_busy, attack_active, attack_start, cooldown_active;
  logic [1:0] attack_type, combo_count;
  logic [5:0] attack_frame;

  int errors = 0;
  int checks = 0;

  player_attack_combo dut (
    .clk             (clk),
    .reset           (reset),
    .SCEN            (SCEN),
    .attack_enable   (attack_enable),
    .attack1         (attack1),
    .attack2         (attack2),
    .attack3         (attack3),
    .hit_stun        (hit_stun),
    .attack_busy     (attack_busy),
    .attack_active   (attack_active),
    .attack_type     (attack_type),
    .attack_frame    (attack_frame),
    .attack_start    (attack_start),
    .cooldown_active (cooldown_active),
    .combo_count     (combo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One SCEN tick; outputs are sampled 1 time unit after the edge.
  task automatic tk(input logic [2:0] btn, input logic stun, input logic en);
    @(negedge clk);
    {attack3, attack2, attack1} = btn;
    hit_stun      = stun;
    attack_enable = en;
    SCEN          = 1'b1;
    @(posedge clk);
    #1;
    SCEN          = 1'b0;
    {attack3, attack2, attack1} = 3'b000;
    hit_stun      = 1'b0;
    attack_enable = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tk(3'b000, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; SCEN = 1'b0; attack_enable = 1'b1;
    attack1 = 1'b0; attack2 = 1'b0; attack3 = 1'b0; hit_stun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", attack_busy, 0);
    chk("rst_type", attack_type, 0);
    chk("rst_frame", attack_frame, 0);
    chk("rst_cd", cooldown_active, 0);
    @(negedge clk) reset = 1'b0;

    // Single ATK1 with cooldown.
    tk(3'b001, 1'b0, 1'b1);
    chk("t1_type", attack_type, 1);
    chk("t1_frame0", attack_frame, 0);
    chk("t1_busy", attack_busy, 1);
    chk("t1_start", attack_start, 1);
    chk("t1_active0", attack_active, 0);
    @(posedge clk); #1;
    chk("t1_start_clr", attack_start, 0);
    for (int i = 1; i <= 17; i++) begin
      tk(3'b000, 1'b0, 1'b1);
      chk("t1_frame", attack_frame, i);
      chk("t1_active", attack_active, (i >= 4 && i <= 10) ? 1 : 0);
    end
    for (int i = 18; i <= 25; i++) begin
      tk((i == 22) ? 3'b001 : 3'b000, 1'b0, 1'b1);
      chk("t1_cd", cooldown_active, 1);
      chk("t1_cd_busy", attack_busy, 0);
      chk("t1_cd_type", attack_type, 0);
    end
    tk(3'b001, 1'b0, 1'b1);
    chk("t1_restart_busy", attack_busy, 1);
    chk("t1_restart_cd", cooldown_active, 0);
    chk("t1_restart_frame", attack_frame, 0);
    tk(3'b000, 1'b1, 1'b1);
    chk("t1_stun_clear", attack_busy, 0);

    // ATK1 chained into ATK2.
    tk(3'b001, 1'b0, 1'b1);
    run(13);
    tk(3'b010, 1'b0, 1'b1);
    run(3);
    chk("t2_pre_frame", attack_frame, 17);
    tk(3'b000, 1'b0, 1'b1);
    chk("t2_type", attack_type, 2);
    chk("t2_frame", attack_frame, 0);
    chk("t2_combo", combo_count, 1);
    chk("t2_start", attack_start, 1);
    chk("t2_cd", cooldown_active, 0);
    run(5);
    chk("t2_act5", attack_active, 0);
    run(1);
    chk("t2_act6", attack_active, 1);
    run(8);
    chk("t2_act14", attack_active, 1);
    run(1);
    chk("t2_act15", attack_active, 0);
    tk(3'b000, 1'b1, 1'b1);

    // Early press is dropped.
    tk(3'b001, 1'b0, 1'b1);
    run(4);
    tk(3'b010, 1'b0, 1'b1);
    run(12);
    chk("t3_frame17", attack_frame, 17);
    tk(3'b000, 1'b0, 1'b1);
    chk("t3_cd", cooldown_active, 1);
    chk("t3_type", attack_type, 0);
    chk("t3_busy", attack_busy, 0);
    tk(3'b000, 1'b1, 1'b1);
    chk("t3_stun_cd", cooldown_active, 0);

    // Full chain 1->2->3, fourth press refused at the combo limit.
    tk(3'b001, 1'b0, 1'b1);
    run(15);
    tk(3'b010, 1'b0, 1'b1);
    run(1);
    tk(3'b000, 1'b0, 1'b1);
    chk("t4_type2", attack_type, 2);
    chk("t4_combo1", combo_count, 1);
    run(20);
    tk(3'b100, 1'b0, 1'b1);
    run(2);
    chk("t4_frame23", attack_frame, 23);
    tk(3'b000, 1'b0, 1'b1);
    chk("t4_type3", attack_type, 3);
    chk("t4_combo2", combo_count, 2);
    run(26);
    tk(3'b001, 1'b0, 1'b1);
    run(2);
    chk("t4_frame29", attack_frame, 29);
    tk(3'b000, 1'b0, 1'b1);
    chk("t4_end_busy", attack_busy, 0);
    chk("t4_end_cd", cooldown_active, 1);
    chk("t4_end_type", attack_type, 0);
    chk("t4_end_combo", combo_count, 0);
    tk(3'b000, 1'b1, 1'b1);

    // Priority and hit-stun.
    tk(3'b101, 1'b0, 1'b1);
    chk("t5_prio", attack_type, 3);
    run(7);
    chk("t5_frame7", attack_frame, 7);
    tk(3'b010, 1'b1, 1'b1);
    chk("t5_stun_busy", attack_busy, 0);
    chk("t5_stun_active", attack_active, 0);
    chk("t5_stun_frame", attack_frame, 0);
    chk("t5_stun_cd", cooldown_active, 0);
    tk(3'b010, 1'b0, 1'b1);
    chk("t5_restart_type", attack_type, 2);
    chk("t5_restart_busy", attack_busy, 1);
    tk(3'b000, 1'b1, 1'b1);

    // Enable freeze, then asynchronous reset mid-attack.
    tk(3'b001, 1'b0, 1'b1);
    run(8);
    chk("t6_frame8", attack_frame, 8);
    for (int i = 0; i < 5; i++) begin
      tk(3'b100, 1'b0, 1'b0);
      chk("t6_hold_frame", attack_frame, 8);
      chk("t6_hold_active", attack_active, 1);
      chk("t6_hold_type", attack_type, 1);
    end
    tk(3'b000, 1'b0, 1'b1);
    chk("t6_resume", attack_frame, 9);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", attack_busy, 0);
    chk("t6_rst_active", attack_active, 0);
    chk("t6_rst_frame", attack_frame, 0);
    chk("t6_rst_type", attack_type, 0);
    @(negedge clk) reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
